// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART host port: FSM state encodings
// and synchronizer depth.
package uart_host_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_PULSE,
      TX_WAIT_LO,
      TX_WAIT_HI
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_PULSE,
      RX_WAIT_LO
   } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead head, occupancy count and full/empty flags.
// Push is refused when full regardless of a same-cycle pop.
module byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   // Empty FIFO presents zero so the head reads 0 straight out of reset.
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push_ok) - LW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_host_port.sv
// User-side endpoint of the board UART link: buffers bytes in both directions
// and runs the txclk/rxclk pulse handshakes against the wrapper's status pins.
module uart_host_port
   import uart_host_pkg::*;
#(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned PULSE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [7:0]              tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic [7:0]              rx_data,
   output logic                    rx_valid,
   input  logic                    rx_ready,
   output logic [7:0]              txdata,
   output logic                    txclk,
   input  logic                    txready,
   input  logic [7:0]              rxdata,
   output logic                    rxclk,
   input  logic                    rxready,
   output logic [$clog2(DEPTH):0]  tx_level,
   output logic [$clog2(DEPTH):0]  rx_level
);

   localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] tx_sync;
   logic [SYNC_STAGES-1:0] rx_sync;
   logic                   txready_s;
   logic                   rxready_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_sync <= '0;
         rx_sync <= '0;
      end else begin
         tx_sync <= {tx_sync[SYNC_STAGES-2:0], txready};
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], rxready};
      end
   end

   assign txready_s = tx_sync[SYNC_STAGES-1];
   assign rxready_s = rx_sync[SYNC_STAGES-1];

   logic [7:0] tx_head;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_pop;
   logic       rx_full;
   logic       rx_empty;
   logic       rx_push;

   byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_valid),
      .din     (tx_data),
      .pop     (tx_pop),
      .head    (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (tx_level)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_push),
      .din     (rxdata),
      .pop     (rx_ready),
      .head    (rx_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .level   (rx_level)
   );

   assign tx_ready = ~tx_full;
   assign rx_valid = ~rx_empty;

   tx_state_t     tx_state;
   tx_state_t     tx_next;
   logic [CW-1:0] tx_cnt;
   logic          tx_done;

   assign tx_done = (tx_cnt == CW'(PULSE_CYCLES - 1));

   // txclk is a one-cycle delayed copy of TX_PULSE, so it rises the cycle after txdata loads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         txdata   <= '0;
         txclk    <= 1'b0;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= (tx_state == TX_PULSE && !tx_done) ? tx_cnt + CW'(1) : '0;
         txclk    <= (tx_state == TX_PULSE);
         if (tx_pop) txdata <= tx_head;
      end
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:    if (!tx_empty && txready_s) tx_next = TX_PULSE;
         TX_PULSE:   if (tx_done)                tx_next = TX_WAIT_LO;
         TX_WAIT_LO: if (!txready_s)             tx_next = TX_WAIT_HI;
         TX_WAIT_HI: if (txready_s)              tx_next = TX_IDLE;
         default:                                tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_pop = (tx_state == TX_IDLE) && !tx_empty && txready_s;
   end

   rx_state_t     rx_state;
   rx_state_t     rx_next;
   logic [CW-1:0] rx_cnt;
   logic          rx_done;

   assign rx_done = (rx_cnt == CW'(PULSE_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rxclk    <= 1'b0;
      end else begin
         rx_state <= rx_next;
         rx_cnt   <= (rx_state == RX_PULSE && !rx_done) ? rx_cnt + CW'(1) : '0;
         rxclk    <= (rx_state == RX_PULSE);
      end
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:    if (rxready_s && !rx_full) rx_next = RX_PULSE;
         RX_PULSE:   if (rx_done)               rx_next = RX_WAIT_LO;
         RX_WAIT_LO: if (!rxready_s)            rx_next = RX_IDLE;
         default:                               rx_next = RX_IDLE;
      endcase
   end

   // A full RX FIFO withholds the acknowledge, leaving the byte with the wrapper.
   always_comb begin
      rx_push = (rx_state == RX_IDLE) && rxready_s && !rx_full;
   end

endmodule

// File: tb/tb_uart_host_port.sv
// Self-checking bench for uart_host_port: wrapper-side pin models, directed
// handshake sequences, a table-driven TX burst and a randomized stream phase.
module tb_uart_host_port;

   localparam int unsigned DEPTH        = 8;
   localparam int unsigned PULSE_CYCLES = 4;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic [7:0] tx_data  = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [7:0] txdata;
   logic       txclk;
   logic       txready  = 1'b1;
   logic [7:0] rxdata   = '0;
   logic       rxclk;
   logic       rxready  = 1'b0;
   logic [3:0] tx_level;
   logic [3:0] rx_level;

   uart_host_port #(.DEPTH(DEPTH), .PULSE_CYCLES(PULSE_CYCLES)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .txdata   (txdata),
      .txclk    (txclk),
      .txready  (txready),
      .rxdata   (rxdata),
      .rxclk    (rxclk),
      .rxready  (rxready),
      .tx_level (tx_level),
      .rx_level (rx_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // TX wrapper model: latches txdata on each txclk rise, then reports busy.
   logic       tx_hold   = 1'b0;
   int         tx_lo_fix = 0;
   int         tx_lo_cnt = 0;
   logic       txclk_p   = 1'b0;
   int         tx_hi     = 0;
   int         tx_pulses = 0;
   logic [7:0] tx_seen[$];

   always @(negedge clk) begin
      if (!reset_n) tx_hi = 0;
      else if (txclk) tx_hi++;
      else if (tx_hi > 0) begin
         check("txclk_width", tx_hi, PULSE_CYCLES);
         tx_hi = 0;
      end
      if (txclk && !txclk_p) begin
         check("txclk_while_busy", txready, 1);
         tx_seen.push_back(txdata);
         tx_pulses++;
         tx_lo_cnt = (tx_lo_fix != 0) ? tx_lo_fix : int'($urandom_range(14, 8));
      end else if (tx_lo_cnt > 0) begin
         tx_lo_cnt--;
      end
      txclk_p = txclk;
      txready = !(tx_hold || tx_lo_cnt > 0);
   end

   // RX wrapper model: offers rx_src bytes in order, holds each until rxclk rises.
   logic [7:0] rx_src[$];
   logic [7:0] rx_acked[$];
   int         rx_idx    = 0;
   int         rx_st     = 0;
   int         rx_wait   = 0;
   logic       rxclk_p   = 1'b0;
   int         rx_hi     = 0;
   int         rx_pulses = 0;
   logic       rx_rise;

   always @(negedge clk) begin
      if (!reset_n) rx_hi = 0;
      else if (rxclk) rx_hi++;
      else if (rx_hi > 0) begin
         check("rxclk_width", rx_hi, PULSE_CYCLES);
         rx_hi = 0;
      end
      rx_rise = rxclk && !rxclk_p;
      if (rx_rise && rx_st != 2) check("rxclk_unexpected", 1, 0);
      case (rx_st)
         0: if (rx_wait > 0) rx_wait--;
            else if (rx_idx < rx_src.size()) begin
               rxdata = rx_src[rx_idx];
               rx_st  = 1;
            end
         1: begin
               rxready = 1'b1;
               rx_st   = 2;
            end
         2: if (rx_rise) begin
               rx_acked.push_back(rx_src[rx_idx]);
               rx_idx++;
               rx_pulses++;
               rx_wait = $urandom_range(2, 0);
               rx_st   = 3;
            end
         default:
            if (rx_wait > 0) rx_wait--;
            else begin
               rxready = 1'b0;
               rxdata  = 8'($urandom);
               rx_wait = $urandom_range(7, 4);
               rx_st   = 0;
            end
      endcase
      rxclk_p = rxclk;
   end

   function automatic logic rx_model_idle();
      return (rx_st == 0) && (rx_idx == rx_src.size());
   endfunction

   // User-side scoreboard: accepted pushes and popped bytes.
   logic [7:0] tx_exp[$];
   logic [7:0] rx_got[$];

   task automatic cycle();
      if (tx_valid && tx_ready) tx_exp.push_back(tx_data);
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) cycle();
   endtask

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       exp_ready;
      logic [3:0] exp_level;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int t0;
      int a0;
      int p0;
      int s0;
      int nrand;

      for (int i = 0; i < 10; i++) begin
         tbl[i].valid     = (i < 9);
         tbl[i].data      = 8'h10 + 8'(i);
         tbl[i].exp_ready = (i < 8);
         tbl[i].exp_level = (i < 8) ? 4'(i + 1) : 4'd8;
      end

      // Reset values
      @(posedge clk); #1;
      cycles(2);
      check("rst_txdata", txdata, 0);
      check("rst_txclk", txclk, 0);
      check("rst_rxclk", rxclk, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_tx_level", tx_level, 0);
      check("rst_rx_level", rx_level, 0);
      reset_n = 1'b1;
      cycles(4);

      // Basic TX
      tx_lo_fix = 10;
      t0 = tx_seen.size();
      p0 = tx_pulses;
      tx_data = 8'h41; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      check("tx_level_after_push", tx_level, 1);
      check("txdata_not_yet", txdata, 0);
      cycle();
      check("txdata_loaded", txdata, 8'h41);
      check("txclk_not_yet", txclk, 0);
      check("tx_level_after_pop", tx_level, 0);
      cycle();
      check("txclk_rise", txclk, 1);
      cycles(30);
      check("basic_tx_pulses", tx_pulses - p0, 1);
      check("basic_tx_count", tx_seen.size() - t0, 1);
      if (tx_seen.size() > t0) check("basic_tx_byte", tx_seen[t0], 8'h41);
      tx_lo_fix = 0;

      // TX burst into a held-off wrapper, table driven
      tx_hold = 1'b1;
      cycles(4);
      tx_exp.delete();
      t0 = tx_seen.size();
      p0 = tx_pulses;
      for (int i = 0; i < 10; i++) begin
         tx_valid = tbl[i].valid;
         tx_data  = tbl[i].data;
         check("burst_tx_ready", tx_ready, tbl[i].exp_ready);
         cycle();
         check("burst_tx_level", tx_level, tbl[i].exp_level);
      end
      check("burst_accepted", tx_exp.size(), 8);

      // Push against a full FIFO on the very edge the FSM pops
      tx_valid = 1'b1; tx_data = 8'hEE;
      tx_hold  = 1'b0;
      k = 0;
      while (txdata != 8'h10 && k < 12) begin
         cycle();
         k++;
      end
      tx_valid = 1'b0;
      check("full_pop_found", txdata, 8'h10);
      check("full_push_pop_level", tx_level, 7);
      k = 0;
      while (tx_seen.size() - t0 < 8 && k < 800) begin
         cycle();
         k++;
      end
      check("burst_tx_count", tx_seen.size() - t0, 8);
      for (int i = 0; i < 8; i++)
         if (t0 + i < tx_seen.size()) check("burst_tx_order", tx_seen[t0 + i], 8'h10 + 8'(i));
      cycles(25);
      check("burst_tx_pulses", tx_pulses - p0, 8);

      // Basic RX
      rx_got.delete();
      a0 = rx_acked.size();
      p0 = rx_pulses;
      rx_src.push_back(8'h5A);
      k = 0;
      while (!rxready && k < 20) begin cycle(); k++; end
      check("rx_raise_seen", rxready, 1);
      k = 0;
      while (!rx_valid && k < 8) begin cycle(); k++; end
      check("rx_latency_le4", (k <= 4), 1);
      check("rx_head", rx_data, 8'h5A);
      k = 0;
      while (!rx_model_idle() && k < 40) begin cycle(); k++; end
      cycles(8);
      check("basic_rx_pulses", rx_pulses - p0, 1);
      check("basic_rx_rxready_low", rxready, 0);
      rx_ready = 1'b1;
      cycle();
      rx_ready = 1'b0;
      check("basic_rx_empty", rx_valid, 0);
      check("basic_rx_popcount", rx_got.size(), 1);
      if (rx_got.size() > 0) check("basic_rx_pop", rx_got[0], 8'h5A);

      // RX backpressure
      rx_got.delete();
      a0 = rx_acked.size();
      for (int i = 0; i < 9; i++) rx_src.push_back(8'h80 + 8'(i));
      k = 0;
      while (rx_level != 4'd8 && k < 300) begin cycle(); k++; end
      cycles(30);
      check("bp_rx_level", rx_level, 8);
      check("bp_rxready_held", rxready, 1);
      check("bp_rxclk_low", rxclk, 0);
      check("bp_acks", rx_acked.size() - a0, 8);
      rx_ready = 1'b1;
      cycle();
      rx_ready = 1'b0;
      if (rx_got.size() > 0) check("bp_first_pop", rx_got[0], 8'h80);
      k = 0;
      while (!rx_model_idle() && k < 40) begin cycle(); k++; end
      check("bp_rx_level_refill", rx_level, 8);
      check("bp_acks_after_pop", rx_acked.size() - a0, 9);
      rx_ready = 1'b1;
      k = 0;
      while (rx_valid && k < 20) begin cycle(); k++; end
      rx_ready = 1'b0;
      check("bp_pop_count", rx_got.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < rx_got.size()) check("bp_pop_order", rx_got[i], 8'h80 + 8'(i));

      // RX push and pop on the same edge at level 3
      rx_got.delete();
      rx_src.push_back(8'hA0); rx_src.push_back(8'hA1); rx_src.push_back(8'hA2);
      k = 0;
      while (!(rx_level == 4'd3 && rx_model_idle()) && k < 200) begin cycle(); k++; end
      check("sim_rx_level_pre", rx_level, 3);
      rx_src.push_back(8'hA3);
      k = 0;
      while (!rxready && k < 20) begin cycle(); k++; end
      cycle();
      rx_ready = 1'b1;
      cycle();
      rx_ready = 1'b0;
      check("sim_rx_level", rx_level, 3);
      if (rx_got.size() > 0) check("sim_rx_pop", rx_got[0], 8'hA0);
      cycles(2);
      check("sim_rx_level_hold", rx_level, 3);
      k = 0;
      while (!rx_model_idle() && k < 40) begin cycle(); k++; end
      rx_ready = 1'b1;
      k = 0;
      while (rx_valid && k < 20) begin cycle(); k++; end
      rx_ready = 1'b0;
      check("sim_rx_count", rx_got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < rx_got.size()) check("sim_rx_order", rx_got[i], 8'hA0 + 8'(i));

      // Reset during TX_PULSE with two bytes held in RX
      rx_src.push_back(8'hB0); rx_src.push_back(8'hB1);
      k = 0;
      while (!(rx_level == 4'd2 && rx_model_idle()) && k < 200) begin cycle(); k++; end
      check("rst_mid_rx_level_pre", rx_level, 2);
      tx_data = 8'h77; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      k = 0;
      while (!txclk && k < 10) begin cycle(); k++; end
      check("rst_mid_txclk_pre", txclk, 1);
      cycle();
      reset_n = 1'b0;
      #1;
      check("rst_mid_txclk", txclk, 0);
      check("rst_mid_rxclk", rxclk, 0);
      check("rst_mid_tx_level", tx_level, 0);
      check("rst_mid_rx_level", rx_level, 0);
      check("rst_mid_tx_ready", tx_ready, 1);
      check("rst_mid_rx_valid", rx_valid, 0);
      check("rst_mid_txdata", txdata, 0);
      cycles(2);
      reset_n = 1'b1;
      k = 0;
      while (!txready && k < 30) begin cycle(); k++; end
      cycles(4);
      t0 = tx_seen.size();
      tx_data = 8'h33; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      k = 0;
      while (tx_seen.size() == t0 && k < 20) begin cycle(); k++; end
      check("post_rst_tx_count", tx_seen.size() - t0, 1);
      if (tx_seen.size() > t0) check("post_rst_tx_byte", tx_seen[t0], 8'h33);
      cycles(25);

      // Randomized streams in both directions
      tx_exp.delete();
      rx_got.delete();
      t0 = tx_seen.size();
      s0 = rx_src.size();
      nrand = 40;
      for (int i = 0; i < nrand; i++) rx_src.push_back(8'($urandom));
      for (int c = 0; c < 1500; c++) begin
         tx_valid = ($urandom_range(3, 0) != 0);
         tx_data  = 8'($urandom);
         rx_ready = 1'($urandom_range(1, 0));
         cycle();
      end
      tx_valid = 1'b0;
      rx_ready = 1'b1;
      k = 0;
      while (!((tx_seen.size() - t0 == tx_exp.size()) && rx_model_idle() && !rx_valid) && k < 4000) begin
         cycle();
         k++;
      end
      rx_ready = 1'b0;
      check("rand_drain_done", (k < 4000), 1);
      check("rand_tx_count", tx_seen.size() - t0, tx_exp.size());
      for (int i = 0; i < tx_exp.size(); i++)
         if (t0 + i < tx_seen.size()) check("rand_tx_byte", tx_seen[t0 + i], tx_exp[i]);
      check("rand_rx_count", rx_got.size(), nrand);
      for (int i = 0; i < nrand; i++)
         if (i < rx_got.size()) check("rand_rx_byte", rx_got[i], rx_src[s0 + i]);
      check("rand_tx_level_end", tx_level, 0);
      check("rand_rx_level_end", rx_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
